// File: rtl/tmr_axil_regfile.sv
// Single replica of an eight-entry AXI4-Lite register file sitting behind the TMR voter.
// Defining REGFILE_FAULT_INJECT_EN turns register 7 into an XOR fault mask applied to reads of registers 0-6.
module tmr_axil_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_NUM_REGS         = 8
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int          STRB_W      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Handshake rule on every channel: a beat transfers on the rising edge where valid && ready are both high;
    // valid never waits on ready, and a response holds valid and payload stable until it transfers.

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    typedef struct packed {
        w_state_t w_state;
        r_state_t r_state;
        logic     aw_latched;
        logic     w_latched;
    } fsm_dbg_t;

    w_state_t                        w_state;
    r_state_t                        r_state;
    fsm_dbg_t                        fsm_dbg;
    logic [C_S_AXI_DATA_WIDTH-1:0]   regs [C_NUM_REGS];

    logic                            aw_latched;
    logic                            w_latched;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]               w_strb_q;
    logic                            bvalid_q;
    logic [1:0]                      bresp_q;

    logic                            rvalid_q;
    logic [1:0]                      rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;

    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   cur_awaddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   cur_wdata;
    logic [STRB_W-1:0]               cur_wstrb;
    logic                            w_in_range;
    logic [2:0]                      w_idx;
    logic                            r_in_range;
    logic [2:0]                      r_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_value;
    logic                            unused_ok;

    assign s_axi_awready = !s_axi_reset && (w_state == W_IDLE) && !aw_latched;
    assign s_axi_wready  = !s_axi_reset && (w_state == W_IDLE) && !w_latched;
    assign s_axi_arready = !s_axi_reset && (r_state == R_IDLE);
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // A beat arriving on this edge takes priority over the (necessarily empty) latch for its channel.
    assign cur_awaddr = aw_hs ? s_axi_awaddr : aw_addr_q;
    assign cur_wdata  = w_hs ? s_axi_wdata : w_data_q;
    assign cur_wstrb  = w_hs ? s_axi_wstrb : w_strb_q;
    assign commit     = (w_state == W_IDLE) && (aw_latched || aw_hs) && (w_latched || w_hs);

    assign w_in_range = (cur_awaddr[C_S_AXI_ADDR_WIDTH-1:5] == '0);
    assign w_idx      = cur_awaddr[4:2];
    assign r_in_range = (s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:5] == '0);
    assign r_idx      = s_axi_araddr[4:2];

    assign fsm_dbg = '{w_state: w_state, r_state: r_state, aw_latched: aw_latched, w_latched: w_latched};

`ifdef REGFILE_FAULT_INJECT_EN
    localparam logic [2:0] MASK_IDX = 3'(C_NUM_REGS - 1);

    always_comb begin
        rd_value = regs[r_idx];
        if (r_idx != MASK_IDX) begin
            rd_value = regs[r_idx] ^ regs[MASK_IDX];
        end
    end
`else
    always_comb begin
        rd_value = regs[r_idx];
    end
`endif

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            w_state    <= W_IDLE;
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_latched <= 1'b1;
                        aw_addr_q  <= s_axi_awaddr;
                    end
                    if (w_hs) begin
                        w_latched <= 1'b1;
                        w_data_q  <= s_axi_wdata;
                        w_strb_q  <= s_axi_wstrb;
                    end
                    if (commit) begin
                        w_state  <= W_RESP;
                        bvalid_q <= 1'b1;
                        if (w_in_range) begin
                            bresp_q <= RESP_OKAY;
                            for (int b = 0; b < STRB_W; b++) begin
                                if (cur_wstrb[b]) begin
                                    regs[w_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                                end
                            end
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state    <= W_IDLE;
                        bvalid_q   <= 1'b0;
                        aw_latched <= 1'b0;
                        w_latched  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reads sample regs before this edge's write lands, so a same-edge collision returns the old value.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state  <= R_DATA;
                        rvalid_q <= 1'b1;
                        rresp_q  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                        rdata_q  <= r_in_range ? rd_value : '0;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_state  <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, cur_awaddr[1:0], s_axi_araddr[1:0], fsm_dbg};

endmodule

// File: tb/tb_tmr_axil_regfile.sv
// Self-checking bench for tmr_axil_regfile: directed scenarios plus randomized traffic against an array model.
// Build with +define+REGFILE_FAULT_INJECT_EN to check the fault-mask variant.
module tb_tmr_axil_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot = 3'b000;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot = 3'b000;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] model [8];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    tmr_axil_regfile dut (
        .s_axi_aclk    (clk),
        .s_axi_reset   (rst),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [31:0] addr);
        return addr[31:5] == 27'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        int idx;
        if (!in_range(addr)) return 32'h0;
        idx = int'(addr[4:2]);
`ifdef REGFILE_FAULT_INJECT_EN
        if (idx != 7) return model[idx] ^ model[7];
`endif
        return model[idx];
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return in_range(addr) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (!in_range(addr)) return;
        idx = int'(addr[4:2]);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, output logic [1:0] resp, output int lat);
        int   cyc;
        bit   aw_done;
        bit   w_done;
        logic aw_r;
        logic w_r;
        cyc = 0; aw_done = 0; w_done = 0; lat = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc <= 50) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_r = awready;
            w_r  = wready;
            tick();
            if (awvalid && aw_r) aw_done = 1;
            if (wvalid && w_r) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) lat = 999;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic drive_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                              output int lat);
        int   cyc;
        bit   done;
        logic ar_r;
        cyc = 0; done = 0; lat = 0;
        araddr = addr;
        while (!done && cyc <= 50) begin
            arvalid = 1'b1;
            ar_r = arready;
            tick();
            if (ar_r) done = 1;
            cyc++;
        end
        arvalid = 1'b0;
        if (!done) lat = 999;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_ready: got %b want 000", {awready, wready, arready});
        else pass_cnt++;
        total_cnt++;
        if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'h0)
            $display("FAIL reset_outputs: bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h want all 0", bvalid, rvalid, bresp, rresp, rdata);
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        tick();
        total_cnt++;
        if ({awready, wready, arready} !== 3'b111) $display("FAIL release_ready: got %b want 111", {awready, wready, arready});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            drive_read(32'(i * 4), d, r, lat);
            total_cnt++;
            if (d !== 32'h0 || r !== 2'b00 || lat !== 0) $display("FAIL reset_reg%0d: got %h/%b lat %0d want 0/00 lat 0", i, d, r, lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        drive_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
        model_write(32'h04, 32'hDEADBEEF, 4'hF);
        total_cnt++;
        if (r !== 2'b00 || lat !== 0) $display("FAIL wr_bresp: got %b lat %0d want 00 lat 0", r, lat);
        else pass_cnt++;
        drive_read(32'h04, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h04) || r !== 2'b00 || lat !== 0)
            $display("FAIL wr_readback: got %h/%b lat %0d want %h/00 lat 0", d, r, lat, exp_read(32'h04));
        else pass_cnt++;
    endtask

    task automatic test_out_of_order();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        total_cnt++;
        if (wready !== 1'b0 || awready !== 1'b1) $display("FAIL ooo_ready: got wready=%b awready=%b want 0 1", wready, awready);
        else pass_cnt++;
        repeat (2) begin
            tick();
            total_cnt++;
            if (bvalid !== 1'b0) $display("FAIL ooo_early_bvalid: got %b want 0", bvalid);
            else pass_cnt++;
        end
        awaddr = 32'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        model_write(32'h08, 32'h12345678, 4'h3);
        total_cnt++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) $display("FAIL ooo_commit: got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        else pass_cnt++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        drive_read(32'h08, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h08) || r !== 2'b00) $display("FAIL ooo_readback: got %h/%b want %h/00", d, r, exp_read(32'h08));
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        drive_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, r, lat);
        total_cnt++;
        if (r !== 2'b10) $display("FAIL oor_bresp: got %b want 10", r);
        else pass_cnt++;
        drive_write(32'h8000_0004, 32'hFFFFFFFF, 4'hF, 1, 0, r, lat);
        total_cnt++;
        if (r !== 2'b10) $display("FAIL oor_high_bresp: got %b want 10", r);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            drive_read(32'(i * 4), d, r, lat);
            total_cnt++;
            if (d !== exp_read(32'(i * 4))) $display("FAIL oor_untouched_reg%0d: got %h want %h", i, d, exp_read(32'(i * 4)));
            else pass_cnt++;
        end
        drive_read(32'h40, d, r, lat);
        total_cnt++;
        if (d !== 32'h0 || r !== 2'b10) $display("FAIL oor_read: got %h/%b want 00000000/10", d, r);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_d;
        logic [31:0] wv;
        int          lat;
        wv = $urandom;
        exp_d = exp_read(32'h04);
        awaddr = 32'h10; wdata = wv; wstrb = 4'hF; araddr = 32'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model_write(32'h10, wv, 4'hF);
        // Offer a second write while the response is pending; it must not be taken.
        awaddr = 32'h14; wdata = ~wv;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || rvalid !== 1'b1 || rdata !== exp_d || rresp !== 2'b00)
                $display("FAIL bp_hold_c%0d: bvalid=%b bresp=%b rvalid=%b rdata=%h rresp=%b want 1 00 1 %h 00", c, bvalid, bresp, rvalid, rdata, rresp, exp_d);
            else pass_cnt++;
            total_cnt++;
            if ({awready, wready, arready} !== 3'b000) $display("FAIL bp_ready_c%0d: got %b want 000", c, {awready, wready, arready});
            else pass_cnt++;
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        total_cnt++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111)
            $display("FAIL bp_release: got %b want 00111", {bvalid, rvalid, awready, wready, arready});
        else pass_cnt++;
        drive_read(32'h14, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h14)) $display("FAIL bp_no_second_write: got %h want %h", d, exp_read(32'h14));
        else pass_cnt++;
        drive_read(32'h10, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h10)) $display("FAIL bp_first_write: got %h want %h", d, exp_read(32'h10));
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] old_d;
        logic [31:0] nv;
        int          lat;
        drive_write(32'h0C, $urandom, 4'hF, 0, 0, r, lat);
        model_write(32'h0C, wdata, 4'hF);
        old_d = exp_read(32'h0C);
        nv = $urandom;
        awaddr = 32'h0C; wdata = nv; wstrb = 4'hF; araddr = 32'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(32'h0C, nv, 4'hF);
        total_cnt++;
        if (rvalid !== 1'b1 || rdata !== old_d || bvalid !== 1'b1)
            $display("FAIL collision_old: rvalid=%b rdata=%h bvalid=%b want 1 %h 1", rvalid, rdata, bvalid, old_d);
        else pass_cnt++;
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        drive_read(32'h0C, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h0C)) $display("FAIL collision_new: got %h want %h", d, exp_read(32'h0C));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({awready, wready, arready} !== 3'b000) $display("FAIL mid_reset_ready: got %b want 000", {awready, wready, arready});
        else pass_cnt++;
        rst = 1'b0;
        model_reset();
        tick();
        total_cnt++;
        if ({awready, wready, arready, bvalid} !== 4'b1110) $display("FAIL mid_release: got %b want 1110", {awready, wready, arready, bvalid});
        else pass_cnt++;
        // Only W now: the AW latched before reset must have been discarded.
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (3) begin
            total_cnt++;
            if (bvalid !== 1'b0) $display("FAIL mid_aw_discard: got bvalid %b want 0", bvalid);
            else pass_cnt++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        awaddr = 32'h18; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        repeat (3) begin
            total_cnt++;
            if (bvalid !== 1'b0) $display("FAIL mid_w_discard: got bvalid %b want 0", bvalid);
            else pass_cnt++;
            tick();
        end
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        model_write(32'h18, 32'h0BADF00D, 4'hF);
        total_cnt++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) $display("FAIL mid_finish: got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
        else pass_cnt++;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        drive_read(32'h18, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h18)) $display("FAIL mid_readback: got %h want %h", d, exp_read(32'h18));
        else pass_cnt++;
    endtask

    task automatic test_reg7();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        drive_write(32'h1C, 32'h1, 4'hF, 0, 0, r, lat);
        model_write(32'h1C, 32'h1, 4'hF);
        drive_read(32'h00, d, r, lat);
        total_cnt++;
        if (d !== exp_read(32'h00)) $display("FAIL reg7_effect_on_reg0: got %h want %h", d, exp_read(32'h00));
        else pass_cnt++;
        drive_read(32'h1C, d, r, lat);
        total_cnt++;
        if (d !== 32'h1) $display("FAIL reg7_readback: got %h want 00000001", d);
        else pass_cnt++;
        drive_write(32'h1C, 32'h0, 4'hF, 0, 0, r, lat);
        model_write(32'h1C, 32'h0, 4'hF);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] d;
        logic [31:0] wv;
        logic [3:0]  st;
        logic [1:0]  r;
        logic [1:0]  er;
        int          lat;
        for (int n = 0; n < 80; n++) begin
            addr = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) addr[31:5] = 27'($urandom_range(1, 2047));
            if ($urandom_range(0, 1) == 0) begin
                wv = $urandom;
                st = 4'($urandom_range(0, 15));
                er = exp_resp(addr);
                drive_write(addr, wv, st, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
                model_write(addr, wv, st);
                total_cnt++;
                if (r !== er || lat !== 0) $display("FAIL rnd_write_%0d: addr %h got %b lat %0d want %b lat 0", n, addr, r, lat, er);
                else pass_cnt++;
            end else begin
                exp_q.push_back(exp_read(addr));
                er = exp_resp(addr);
                drive_read(addr, d, r, lat);
                total_cnt++;
                if (d !== exp_q[0] || r !== er || lat !== 0)
                    $display("FAIL rnd_read_%0d: addr %h got %h/%b lat %0d want %h/%b lat 0", n, addr, d, r, lat, exp_q[0], er);
                else pass_cnt++;
                void'(exp_q.pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_write_read();
        test_out_of_order();
        test_out_of_range();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_reg7();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
